digital_clock_controller: RTL and testbench

Timekeeping and time-set controller for the digital clock datapath. It runs on the fast system clock and derives the 1 Hz advance internally from a prescaler. It sequences the hours/minutes/seconds counters through a run mode and three set modes driven by single-cycle button pulses. Its `seconds`/`minutes`/`hours` outputs keep the same widths and ranges as the existing clock outputs, so display logic and benches can use it in place of the free-running clock.

---
 rtl/digital_clock_controller.sv | 143 ++++++++++++++
 tb/tb_digital_clock_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_controller.sv
// Timekeeping and time-set controller: 1 Hz advance from an internal prescaler,
// three set modes for hours/minutes/seconds driven by single-cycle button pulses.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  RUN     | prescaler counts, time advances once per TICKS_PER_SEC edges
//  SET_HR  | prescaler held at 0, inc/dec adjust hours (0..23)
//  SET_MIN | prescaler held at 0, inc/dec adjust minutes (0..59)
//  SET_SEC | prescaler held at 0, inc/dec adjust seconds (0..59)
module digital_clock_controller #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [1:0] mode,
    output logic       tick_1s
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [5:0]    sec_next, min_next;
    logic [4:0]    hr_next;
    logic          tick_next;
    logic          adjust;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec60(input logic [5:0] v);
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] dec24(input logic [4:0] v);
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    // Simultaneous inc and dec cancel out.
    assign adjust = inc_btn ^ dec_btn;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            presc   <= '0;
            seconds <= '0;
            minutes <= '0;
            hours   <= '0;
            tick_1s <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            seconds <= sec_next;
            minutes <= min_next;
            hours   <= hr_next;
            tick_1s <= tick_next;
        end
    end

    always_comb begin
        state_next = state;
        presc_next = '0;
        sec_next   = seconds;
        min_next   = minutes;
        hr_next    = hours;
        tick_next  = 1'b0;

        case (state)
            RUN: begin
                if (presc == PRESC_LAST) begin
                    tick_next = 1'b1;
                    if (seconds == 6'd59) begin
                        sec_next = 6'd0;
                        if (minutes == 6'd59) begin
                            min_next = 6'd0;
                            hr_next  = inc24(hours);
                        end else begin
                            min_next = minutes + 6'd1;
                        end
                    end else begin
                        sec_next = seconds + 6'd1;
                    end
                end else begin
                    presc_next = presc + PRESC_ONE;
                end
                // A partial second is discarded when entering set mode.
                if (mode_btn) begin
                    state_next = SET_HR;
                    presc_next = '0;
                end
            end

            SET_HR: begin
                if (mode_btn) begin
                    state_next = SET_MIN;
                end else if (adjust) begin
                    hr_next = inc_btn ? inc24(hours) : dec24(hours);
                end
            end

            SET_MIN: begin
                if (mode_btn) begin
                    state_next = SET_SEC;
                end else if (adjust) begin
                    min_next = inc_btn ? inc60(minutes) : dec60(minutes);
                end
            end

            SET_SEC: begin
                if (mode_btn) begin
                    state_next = RUN;
                end else if (adjust) begin
                    sec_next = inc_btn ? inc60(seconds) : dec60(seconds);
                end
            end

            default: state_next = RUN;
        endcase
    end

    assign mode = state;

endmodule

// File: tb/tb_digital_clock_controller.sv
// Self-checking bench for digital_clock_controller with TICKS_PER_SEC = 4:
// directed vector table, hand-written corner sequences and a random run against a time-of-day model.
module tb_digital_clock_controller;

    localparam int T = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       dec_btn = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [1:0] mode;
    logic       tick_1s;

    int tests = 0;
    int failures = 0;

    // Reference model: time of day as h/m/s, mode as 0..3, edges since RUN phase start.
    int   mdl_h = 0, mdl_m = 0, mdl_s = 0, mdl_mode = 0, phase = 0;
    logic mdl_tick = 1'b0;

    digital_clock_controller #(.TICKS_PER_SEC(T)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .dec_btn  (dec_btn),
        .seconds  (seconds),
        .minutes  (minutes),
        .hours    (hours),
        .mode     (mode),
        .tick_1s  (tick_1s)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       m;
        logic       i;
        logic       d;
        logic [1:0] e_mode;
        logic [4:0] e_h;
        logic [5:0] e_m;
        logic [5:0] e_s;
        logic       e_tick;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic i, input logic d,
                                input int md, input int h, input int mi, input int s,
                                input logic tk);
        vec_t v;
        v.m = m; v.i = i; v.d = d;
        v.e_mode = 2'(md); v.e_h = 5'(h); v.e_m = 6'(mi); v.e_s = 6'(s);
        v.e_tick = tk;
        return v;
    endfunction

    task automatic model_reset();
        mdl_h = 0; mdl_m = 0; mdl_s = 0; mdl_mode = 0; phase = 0; mdl_tick = 1'b0;
    endtask

    task automatic model_edge(input logic m, input logic i, input logic d);
        int total;
        mdl_tick = 1'b0;
        if (mdl_mode == 0) begin
            phase++;
            if (phase == T) begin
                phase = 0;
                mdl_tick = 1'b1;
                total = (mdl_h * 3600 + mdl_m * 60 + mdl_s + 1) % 86400;
                mdl_h = total / 3600;
                mdl_m = (total / 60) % 60;
                mdl_s = total % 60;
            end
            if (m) phase = 0;
        end else begin
            phase = 0;
        end
        if (m) begin
            mdl_mode = (mdl_mode + 1) % 4;
        end else if (mdl_mode != 0 && i != d) begin
            case (mdl_mode)
                1: mdl_h = (mdl_h + (i ? 1 : 23)) % 24;
                2: mdl_m = (mdl_m + (i ? 1 : 59)) % 60;
                default: mdl_s = (mdl_s + (i ? 1 : 59)) % 60;
            endcase
        end
    endtask

    task automatic step(input logic m, input logic i, input logic d);
        mode_btn = m; inc_btn = i; dec_btn = d;
        model_edge(m, i, d);
        @(posedge Clk);
        #1;
        mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    endtask

    task automatic check(input string name);
        tests++;
        if ({mode, hours, minutes, seconds, tick_1s} !==
            {2'(mdl_mode), 5'(mdl_h), 6'(mdl_m), 6'(mdl_s), mdl_tick}) begin
            failures++;
            $display("FAIL %s: got mode=%0d %0d:%0d:%0d tick=%0d, expected mode=%0d %0d:%0d:%0d tick=%0d",
                     name, mode, hours, minutes, seconds, tick_1s,
                     mdl_mode, mdl_h, mdl_m, mdl_s, mdl_tick);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_zero_now(input string name);
        check_val({name, " mode"}, int'(mode), 0);
        check_val({name, " fields"}, int'({hours, minutes, seconds, tick_1s}), 0);
    endtask

    // Asserts reset between edges, checks the async clear, releases before the next edge.
    task automatic pulse_reset(input string name);
        #1;
        reset = 1'b1;
        #1;
        check_zero_now(name);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic expect_first_tick(input string name);
        for (int k = 1; k <= T; k++) begin
            step(1'b0, 1'b0, 1'b0);
            check_val({name, " tick"}, int'(tick_1s), (k == T) ? 1 : 0);
            check(name);
        end
    endtask

    vec_t vecs[21];
    int   idle_ticks;
    int   r;

    initial begin
        // Reset state and directed table (from 00:00:00, RUN, phase 0).
        #1;
        check_zero_now("reset_state");
        #2;
        reset = 1'b0;
        model_reset();

        vecs[0]  = mk(1, 0, 0, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 1, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 1, 2, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 1, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 1, 1, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 2, 1, 0, 0, 0);
        vecs[6]  = mk(0, 0, 1, 2, 1, 59, 0, 0);
        vecs[7]  = mk(0, 1, 0, 2, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 2, 1, 59, 0, 0);
        vecs[9]  = mk(1, 0, 0, 3, 1, 59, 0, 0);
        vecs[10] = mk(0, 0, 1, 3, 1, 59, 59, 0);
        vecs[11] = mk(0, 0, 1, 3, 1, 59, 58, 0);
        vecs[12] = mk(1, 0, 0, 0, 1, 59, 58, 0);
        vecs[13] = mk(0, 0, 0, 0, 1, 59, 58, 0);
        vecs[14] = mk(0, 1, 0, 0, 1, 59, 58, 0);
        vecs[15] = mk(0, 0, 1, 0, 1, 59, 58, 0);
        vecs[16] = mk(0, 0, 0, 0, 1, 59, 59, 1);
        vecs[17] = mk(0, 0, 0, 0, 1, 59, 59, 0);
        vecs[18] = mk(0, 1, 1, 0, 1, 59, 59, 0);
        vecs[19] = mk(0, 0, 0, 0, 1, 59, 59, 0);
        vecs[20] = mk(0, 0, 0, 0, 2, 0, 0, 1);

        for (int k = 0; k < 21; k++) begin
            step(vecs[k].m, vecs[k].i, vecs[k].d);
            tests++;
            if ({mode, hours, minutes, seconds, tick_1s} !==
                {vecs[k].e_mode, vecs[k].e_h, vecs[k].e_m, vecs[k].e_s, vecs[k].e_tick}) begin
                failures++;
                $display("FAIL vec%0d: got mode=%0d %0d:%0d:%0d tick=%0d, expected mode=%0d %0d:%0d:%0d tick=%0d",
                         k, mode, hours, minutes, seconds, tick_1s, vecs[k].e_mode,
                         vecs[k].e_h, vecs[k].e_m, vecs[k].e_s, vecs[k].e_tick);
            end
        end

        // Async reset mid-run, then first tick after release.
        step(1'b0, 1'b0, 1'b0);
        pulse_reset("async_reset");
        expect_first_tick("after_reset");
        check_val("after_reset seconds", int'(seconds), 1);

        // Carry chain: set 23:59:59, back to RUN, roll over on one edge.
        pulse_reset("pre_carry");
        step(1, 0, 0); step(0, 0, 1);
        step(1, 0, 0); step(0, 0, 1);
        step(1, 0, 0); step(0, 0, 1);
        check("set_235959");
        step(1, 0, 0);
        expect_first_tick("rollover");
        check_val("rollover hms", int'({hours, minutes, seconds}), 0);
        for (int k = 0; k < 240; k++) begin
            step(0, 0, 0);
            check("run240");
        end
        check_val("run240 minutes", int'(minutes), 1);
        check_val("run240 hours/seconds", int'({hours, seconds}), 0);

        // Set and wrap.
        pulse_reset("pre_set");
        step(1, 0, 0);
        check_val("set_hr mode", int'(mode), 1);
        for (int k = 0; k < 25; k++) step(0, 1, 0);
        check_val("hr inc wrap", int'(hours), 1);
        step(0, 0, 1); step(0, 0, 1);
        check_val("hr dec wrap", int'(hours), 23);
        step(1, 0, 0);
        step(0, 0, 1);
        check_val("min dec wrap", int'(minutes), 59);
        check_val("min dec others", int'({hours, seconds}), {5'd23, 6'd0});
        check("set_wrap");

        // Simultaneous events in SET_MIN, then freeze in SET_SEC.
        step(0, 1, 1);
        check_val("inc+dec no change", int'(minutes), 59);
        step(1, 0, 0);
        step(0, 1, 0);
        idle_ticks = 0;
        for (int k = 0; k < 100; k++) begin
            step(0, 0, 0);
            if (tick_1s) idle_ticks++;
            check("freeze");
        end
        check_val("freeze ticks", idle_ticks, 0);
        step(1, 0, 0);
        expect_first_tick("leave_set_sec");

        // mode_btn beats inc_btn in SET_HR.
        step(1, 0, 0);
        step(1, 1, 0);
        check_val("mode+inc mode", int'(mode), 2);
        check_val("mode+inc hours", int'(hours), 23);
        step(1, 0, 0); step(1, 0, 0);
        step(0, 1, 0);
        check("inc_in_run");

        // Reset mid-set with minutes = 37.
        pulse_reset("pre_midset");
        step(1, 0, 0); step(1, 0, 0);
        for (int k = 0; k < 37; k++) step(0, 1, 0);
        check_val("midset minutes", int'(minutes), 37);
        pulse_reset("reset_midset");
        expect_first_tick("after_midset");

        // Random run against the model.
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 15));
            step(r == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            check("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
